// File: rtl/spi_burst_ctrl_pkg.sv
// Shared types and constants for the SPI burst controller and its FIFOs.
package spi_burst_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BSY  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_burst_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spi_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Host-side front end for spi_master: TX/RX byte FIFOs, tick divider and a
// launch FSM that pairs every transmitted byte with exactly one RX entry.
module spi_burst_ctrl
    import spi_burst_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DIV   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              tx_full,
    output logic [AW:0]       tx_count,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rx_empty,
    output logic [AW:0]       rx_count,
    output logic              busy,
    output logic              tx_ovf,
    output logic              rx_udf,
    input  logic              err_clr,
    output logic              tick,
    output logic              m_start,
    output logic [BYTE_W-1:0] m_tx_data,
    input  logic [BYTE_W-1:0] m_rx_data,
    input  logic              m_ready
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t            r_state;
    logic [CW-1:0]     r_div_cnt;
    logic              r_tick;
    logic              r_m_start;
    logic [BYTE_W-1:0] r_m_tx_data;
    logic              r_tx_ovf;
    logic              r_rx_udf;

    logic [BYTE_W-1:0] w_tx_head;
    logic [AW:0]       w_tx_count;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [AW:0]       w_rx_count;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_launch;
    logic              w_rx_push;

    // RX space is reserved at launch, so the completion push can never overflow.
    assign w_launch  = (r_state == ST_IDLE) && !w_tx_empty && !w_rx_full && m_ready;
    assign w_rx_push = (r_state == ST_WAIT_DONE) && m_ready;

    spi_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (BYTE_W)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_launch),
        .o_data  (w_tx_head),
        .o_count (w_tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    spi_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (BYTE_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_rx_push),
        .i_data  (m_rx_data),
        .i_pop   (rd_en),
        .o_data  (rd_data),
        .o_count (w_rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // Free-running divider; tick is asserted while the count sits at DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            if (r_div_cnt == CW'(DIV - 1)) r_div_cnt <= '0;
            else                           r_div_cnt <= r_div_cnt + CW'(1);
            r_tick <= (r_div_cnt == CW'(DIV - 2));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_m_start   <= 1'b0;
            r_m_tx_data <= '0;
        end else begin
            r_m_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_m_tx_data <= w_tx_head;
                        r_m_start   <= 1'b1;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH:    r_state <= ST_WAIT_BSY;
                ST_WAIT_BSY:  if (!m_ready) r_state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (m_ready)  r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; clear wins over a same-cycle set. A full-FIFO write
    // that coincides with a launch pop is accepted, so it is not an overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
        end else if (err_clr) begin
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
        end else begin
            r_tx_ovf <= r_tx_ovf | (wr_en & w_tx_full & ~w_launch);
            r_rx_udf <= r_rx_udf | (rd_en & w_rx_empty);
        end
    end

    assign tx_full   = w_tx_full;
    assign tx_count  = w_tx_count;
    assign rx_empty  = w_rx_empty;
    assign rx_count  = w_rx_count;
    assign busy      = (r_state != ST_IDLE) || (w_tx_count != '0);
    assign tx_ovf    = r_tx_ovf;
    assign rx_udf    = r_rx_udf;
    assign tick      = r_tick;
    assign m_start   = r_m_start;
    assign m_tx_data = r_m_tx_data;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench: three controllers (DIV=4/2/7), each paired with a loopback
// spi_master model that finishes a byte after 16 ticks (one per SCLK edge).
module tb_spi_burst_ctrl;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      wr_en, rd_en, err_clr, hold;
    logic [2:0][7:0] wr_data;

    logic [2:0]      tx_full, rx_empty, busy, tx_ovf, rx_udf, tick_a, m_start_a;
    logic [2:0][3:0] tx_count, rx_count;
    logic [2:0][7:0] rd_data, m_tx_a;

    int total = 0;
    int bad   = 0;
    int nstart = 0;
    int snap;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 4 : ((g == 1) ? 2 : 7);
        logic       r_rdy;
        logic [4:0] r_mcnt;
        logic [7:0] r_sh;
        logic [7:0] r_rx;

        spi_burst_ctrl #(.DEPTH(8), .AW(3), .DIV(D)) u_dut (
            .clk       (clk),
            .rst       (rst_n),
            .wr_en     (wr_en[g]),
            .wr_data   (wr_data[g]),
            .tx_full   (tx_full[g]),
            .tx_count  (tx_count[g]),
            .rd_en     (rd_en[g]),
            .rd_data   (rd_data[g]),
            .rx_empty  (rx_empty[g]),
            .rx_count  (rx_count[g]),
            .busy      (busy[g]),
            .tx_ovf    (tx_ovf[g]),
            .rx_udf    (rx_udf[g]),
            .err_clr   (err_clr[g]),
            .tick      (tick_a[g]),
            .m_start   (m_start_a[g]),
            .m_tx_data (m_tx_a[g]),
            .m_rx_data (r_rx),
            .m_ready   (r_rdy & ~hold[g])
        );

        // Loopback master: MISO tied to MOSI, so the received byte equals the sent one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdy  <= 1'b1;
                r_mcnt <= '0;
                r_sh   <= '0;
                r_rx   <= '0;
            end else if (r_rdy) begin
                if (m_start_a[g]) begin
                    r_rdy  <= 1'b0;
                    r_mcnt <= '0;
                    r_sh   <= m_tx_a[g];
                end
            end else if (tick_a[g]) begin
                if (r_mcnt == 5'd15) begin
                    r_rdy <= 1'b1;
                    r_rx  <= r_sh;
                end
                r_mcnt <= r_mcnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (m_start_a[0]) nstart <= nstart + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int g, input logic [7:0] d);
        wr_en[g]   = 1'b1;
        wr_data[g] = d;
        @(negedge clk);
        wr_en[g]   = 1'b0;
    endtask

    task automatic rd(input int g);
        rd_en[g] = 1'b1;
        @(negedge clk);
        rd_en[g] = 1'b0;
    endtask

    task automatic wait_rx(input int g, input int n, input int budget);
        int t;
        t = 0;
        while (rx_count[g] != 4'(n) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("wait_rx", 32'(rx_count[g]), 32'(n));
    endtask

    task automatic tick_period(input int g, input int d);
        int t;
        int n;
        t = 0;
        while (!tick_a[g] && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("tick_width", 32'(tick_a[g]), 0);
        n = 1;
        while (!tick_a[g] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tick_period", 32'(n), 32'(d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n   = 1'b0;
        wr_en   = '0;
        rd_en   = '0;
        err_clr = '0;
        hold    = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_m_start", 32'(m_start_a[0]), 0);
        chk("rst_m_tx", 32'(m_tx_a[0]), 0);
        chk("rst_tick", 32'(tick_a[0]), 0);
        chk("rst_ovf", 32'(tx_ovf[0]), 0);
        chk("rst_udf", 32'(rx_udf[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_rx_empty", 32'(rx_empty[0]), 1);
        chk("rst_tx_count", 32'(tx_count[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte on every divider setting
        snap = nstart;
        wr_en   = 3'b111;
        wr_data = {8'hC3, 8'h3C, 8'hA5};
        @(negedge clk);
        wr_en   = '0;
        wait_rx(0, 1, 400);
        chk("t1_rd_data", 32'(rd_data[0]), 32'hA5);
        chk("t1_busy", 32'(busy[0]), 0);
        chk("t1_starts", 32'(nstart - snap), 1);
        wait_rx(1, 1, 400);
        chk("t6_div2_data", 32'(rd_data[1]), 32'h3C);
        wait_rx(2, 1, 400);
        chk("t6_div7_data", 32'(rd_data[2]), 32'hC3);
        rd(0); rd(1); rd(2);
        chk("t1_rx_empty", 32'(rx_empty[0]), 1);
        tick_period(0, 4);
        tick_period(1, 2);
        tick_period(2, 7);

        // Back-to-back burst of 8 with the master held off, then released
        hold[0] = 1'b1;
        snap = nstart;
        for (int i = 1; i <= 8; i++) wr(0, 8'(i));
        chk("t2_tx_full", 32'(tx_full[0]), 1);
        chk("t2_tx_count", 32'(tx_count[0]), 8);
        chk("t2_busy", 32'(busy[0]), 1);
        hold[0] = 1'b0;
        wait_rx(0, 8, 1500);
        chk("t2_starts", 32'(nstart - snap), 8);
        chk("t2_tx_empty", 32'(tx_count[0]), 0);

        // RX full blocks the next launch until one entry is read
        snap = nstart;
        wr(0, 8'h55);
        repeat (200) @(negedge clk);
        chk("t3_no_start", 32'(nstart - snap), 0);
        chk("t3_tx_pending", 32'(tx_count[0]), 1);
        chk("t3_head", 32'(rd_data[0]), 32'h01);
        rd(0);
        wait_rx(0, 8, 400);
        chk("t3_one_start", 32'(nstart - snap), 1);
        for (int i = 2; i <= 8; i++) begin
            chk("t2_order", 32'(rd_data[0]), 32'(i));
            rd(0);
        end
        chk("t3_data", 32'(rd_data[0]), 32'h55);
        rd(0);
        chk("t3_rx_empty", 32'(rx_empty[0]), 1);

        // Overflow / underflow flags and clear priority
        hold[0] = 1'b1;
        for (int i = 0; i < 8; i++) wr(0, 8'h10 + 8'(i));
        wr(0, 8'hEE);
        chk("t4_ovf", 32'(tx_ovf[0]), 1);
        chk("t4_count_held", 32'(tx_count[0]), 8);
        rd(0);
        chk("t4_udf", 32'(rx_udf[0]), 1);
        chk("t4_rx_count", 32'(rx_count[0]), 0);
        err_clr[0] = 1'b1;
        wr_en[0]   = 1'b1;
        wr_data[0] = 8'hEF;
        rd_en[0]   = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        wr_en[0]   = 1'b0;
        rd_en[0]   = 1'b0;
        chk("t4_clr_ovf", 32'(tx_ovf[0]), 0);
        chk("t4_clr_udf", 32'(rx_udf[0]), 0);
        hold[0] = 1'b0;
        wait_rx(0, 8, 1500);
        for (int i = 0; i < 8; i++) begin
            chk("t4_order", 32'(rd_data[0]), 32'h10 + 32'(i));
            rd(0);
        end

        // Reset after 3 SCLK edges of a byte
        wr(0, 8'h9A);
        t = 0;
        while (!(g_dut[0].r_rdy == 1'b0 && g_dut[0].r_mcnt == 5'd3) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("t5_edges", 32'(g_dut[0].r_mcnt), 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_m_start", 32'(m_start_a[0]), 0);
        chk("t5_m_tx", 32'(m_tx_a[0]), 0);
        chk("t5_busy", 32'(busy[0]), 0);
        chk("t5_tick", 32'(tick_a[0]), 0);
        chk("t5_tx_count", 32'(tx_count[0]), 0);
        chk("t5_rx_count", 32'(rx_count[0]), 0);
        rst_n = 1'b1;
        snap = nstart;
        repeat (200) @(negedge clk);
        chk("t5_no_rx", 32'(rx_empty[0]), 1);
        chk("t5_no_start", 32'(nstart - snap), 0);
        wr(0, 8'h42);
        wait_rx(0, 1, 400);
        chk("t5_after", 32'(rd_data[0]), 32'h42);
        rd(0);

        // Every instance quiescent and error-free at the end
        for (int g = 0; g < 3; g++) begin
            chk("end_busy", 32'(busy[g]), 0);
            chk("end_full", 32'(tx_full[g]), 0);
            chk("end_rx_empty", 32'(rx_empty[g]), 1);
            chk("end_ovf", 32'(tx_ovf[g]), 0);
            chk("end_udf", 32'(rx_udf[g]), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
